apb_fifo_master: RTL and testbench

APB requester that converts a simple valid/ready command stream into single APB transfers targeting the `apb2fifo` slave. A write command becomes a FIFO push (PADDR=0, PWRITE=1) and a read command becomes a FIFO pop (PADDR=1, PWRITE=0). The block sits directly upstream of `apb2fifo` on the same PCLK and drives its PSELx/PENABLE/PADDR/PWRITE/PWDATA inputs. It returns one response per command, carrying read data, slave-error and timeout status, and keeps a saturating error count.

---
 rtl/apb_fifo_master.sv | 110 +++++++++++
 tb/tb_apb_fifo_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_master.sv
// APB requester for the apb2fifo slave: turns a valid/ready command stream into
// single push/pop transfers and returns one response (data, error, timeout) per command.
module apb_fifo_master #(
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd,
  input  logic [7:0]           cmd_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic                 PADDR,
  output logic                 PWRITE,
  output logic [7:0]           PWDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  input  logic [7:0]           PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        done_err, done_ok, done_to, done;

  assign cmd_ready = (state == IDLE) && !PRESET;
  assign accept    = cmd_valid && cmd_ready;

  // PSLVERR wins over PREADY; timeout only when the slave gave neither
  assign done_err = (state == ACCESS) && PSLVERR;
  assign done_ok  = (state == ACCESS) && !PSLVERR && PREADY;
  assign done_to  = (state == ACCESS) && !PSLVERR && !PREADY && (wait_cnt == WAIT_LAST);
  assign done     = done_err || done_ok || done_to;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    PSELx      = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        PSELx      = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/direction/data are captured at acceptance and held for the whole transfer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR  <= 1'b0;
      PWRITE <= 1'b0;
      PWDATA <= 8'h00;
    end else if (accept) begin
      PADDR  <= cmd_rd;
      PWRITE <= !cmd_rd;
      PWDATA <= cmd_rd ? 8'h00 : cmd_wdata;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)                          wait_cnt <= 16'd0;
    else if (state == SETUP)             wait_cnt <= 16'd0;
    else if (state == ACCESS && !done)   wait_cnt <= wait_cnt + 16'd1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_rdata   <= (done_ok && PADDR) ? PRDATA : 8'h00;
        rsp_err     <= done_err || done_to;
        rsp_timeout <= done_to;
      end
      if ((done_err || done_to) && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_fifo_master.sv
// Randomized scoreboard bench for apb_fifo_master; the bench plays the apb2fifo
// slave using a queue model of a 4-deep FIFO and predicts every response.
module tb_apb_fifo_master;

  localparam int TIMEOUT   = 4;
  localparam int ERR_CNT_W = 8;
  localparam int DEPTH     = 4;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic                 cmd_valid, cmd_ready, cmd_rd;
  logic [7:0]           cmd_wdata;
  logic                 rsp_valid, rsp_err, rsp_timeout;
  logic [7:0]           rsp_rdata;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 PSELx, PENABLE, PADDR, PWRITE;
  logic [7:0]           PWDATA;
  logic                 PREADY, PSLVERR;
  logic [7:0]           PRDATA;

  typedef struct {
    logic [7:0] rdata;
    bit         err;
    bit         to;
    int         cnt;
    int         cyc;
  } rsp_t;

  rsp_t       sb[$];
  rsp_t       mon_e;
  logic [7:0] model_q[$];
  int         model_err = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;

  apb_fifo_master #(.TIMEOUT(TIMEOUT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .err_cnt(err_cnt),
    .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One command end to end; called and returns at a falling edge with the DUT idle
  task automatic applyStimulus(input bit rd, input logic [7:0] wd, input int w);
    bit         to, slverr;
    logic [7:0] rdat;
    logic [11:0] bus_setup, bus_access;
    rsp_t       e;
    int         nacc;
    to     = (w >= TIMEOUT);
    slverr = 1'b0;
    rdat   = 8'h00;
    if (!to) begin
      if (rd) begin
        if (model_q.size() == 0) slverr = 1'b1;
        else rdat = model_q.pop_front();
      end else begin
        if (model_q.size() == DEPTH) slverr = 1'b1;
        else model_q.push_back(wd);
      end
    end
    if ((to || slverr) && model_err < ERR_MAX) model_err++;
    e.rdata = rdat;
    e.err   = to || slverr;
    e.to    = to;
    e.cnt   = model_err;
    e.cyc   = cyc + 3 + (to ? TIMEOUT - 1 : w);
    sb.push_back(e);

    bus_setup  = {1'b1, 1'b0, rd, ~rd, (rd ? 8'h00 : wd)};
    bus_access = {1'b1, 1'b1, rd, ~rd, (rd ? 8'h00 : wd)};

    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_wdata = wd;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    @(negedge PCLK);
    checkOutput("bus_setup", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA}), 32'(bus_setup));
    cmd_rd    = 1'($urandom);
    cmd_wdata = 8'($urandom);
    PREADY    = 1'($urandom);
    PSLVERR   = 1'($urandom);
    PRDATA    = 8'($urandom);

    nacc = to ? TIMEOUT : w + 1;
    for (int k = 0; k < nacc; k++) begin
      @(negedge PCLK);
      checkOutput("bus_access", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA}), 32'(bus_access));
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 8'($urandom);
      if (!to && k == w) begin
        if (slverr) PSLVERR = 1'b1;
        else begin
          PREADY = 1'b1;
          if (rd) PRDATA = rdat;
        end
      end
    end

    @(negedge PCLK);
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("bus_idle", 32'({PSELx, PENABLE}), 32'd0);
  endtask

  // Push aborted by reset in its first ACCESS cycle: no response, slave unchanged
  task automatic applyReset();
    cmd_valid = 1'b1;
    cmd_rd    = 1'b0;
    cmd_wdata = 8'($urandom);
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("bus_access_rst", 32'({PSELx, PENABLE}), 32'd3);
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("reset_bus", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA}), 32'd0);
    checkOutput("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    PRESET    = 1'b0;
    model_err = 0;
    @(negedge PCLK);
  endtask

  always @(negedge PCLK) begin
    if (rsp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b, expected no response (cycle %0d)", rsp_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
        checkOutput("err_cnt", 32'(err_cnt), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    bit         rd;
    int         w;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_wdata = 8'h00;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = 8'h00;
    repeat (3) @(negedge PCLK);
    checkOutput("init_bus", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA}), 32'd0);
    checkOutput("init_rsp", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 32'd0);
    checkOutput("init_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("init_cmd_ready", 32'(cmd_ready), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    applyStimulus(1'b0, 8'hA5, 0);
    applyStimulus(1'b1, 8'h00, 0);
    applyStimulus(1'b0, 8'h3C, 1);
    applyStimulus(1'b1, 8'h00, 2);
    applyStimulus(1'b1, 8'h00, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'(i), 0);
    applyStimulus(1'b0, 8'h55, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h00, 0);
    applyStimulus(1'b0, 8'h77, TIMEOUT);
    applyStimulus(1'b1, 8'h00, TIMEOUT + 1);

    for (int i = 0; i < 150; i++) begin
      rd = 1'($urandom);
      if ($urandom_range(0, 9) < 7) w = int'($urandom_range(0, 2));
      else                          w = int'($urandom_range(3, TIMEOUT + 1));
      applyStimulus(rd, 8'($urandom), w);
    end

    applyReset();

    while (model_q.size() > 0) applyStimulus(1'b1, 8'h00, 0);
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 8'h00, int'($urandom_range(0, 1)));
    checkOutput("err_cnt_saturated", 32'(err_cnt), 32'(ERR_MAX));

    repeat (4) @(negedge PCLK);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
